sprite_line_fetcher: RTL and testbench
======================================

// Module: sprite_line_fetcher
// PURPOSE
//  Downstream consumer of a 256x16 sprite ROM (16x16 sprite, RGB565, one pixel per word,
//  addr = {row[3:0],col[3:0]}). On each hblank start pulse it decides whether the sprite
//  covers the requested scanline, reads that sprite row from the ROM and writes opaque
//  pixels into the VGA line buffer at sprite_x. Sits between the sprite ROM and the line buffer.
// PARAMETERS
//  H_ACTIVE     640      visible pixels per line; writes at x >= H_ACTIVE are clipped
//  TRANSPARENT  16'hF81F colour key; ROM words equal to it are not written
//  SPR_DIM      16       sprite width/height in pixels (fixed 16; ROM addr width 8)
// PORTS
//  clk            in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  start          in   1   one-cycle request pulse; sampled only in IDLE
//  line           in   10  scanline being prepared
//  sprite_x       in   10  sprite left column (latched at start)
//  sprite_y       in   10  sprite top row (latched at start)
//  sprite_en      in   1   sprite visible (latched at start)
//  mirror         in   1   horizontal flip (latched at start; used only with SPRITE_MIRROR_EN)
//  rom_address    out  8   sprite ROM word address
//  rom_chipselect out  1   ROM read strobe
//  rom_clken      out  1   ROM clock enable; constant 1 after reset
//  rom_readdata   in   16  ROM data; valid the cycle after rom_address is presented
//  lb_we          out  1   line-buffer write enable
//  lb_addr        out  10  line-buffer pixel address
//  lb_wdata       out  16  line-buffer pixel data
//  busy           out  1   high in every state except IDLE
//  done           out  1   one-cycle pulse when the line is finished
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; rom_address=0, rom_chipselect=0, lb_we=0,
//    lb_addr=0, lb_wdata=0, busy=0, done=0; rom_clken=0 while reset_n low, 1 after release.
//  - States IDLE->CHECK->FETCH->DRAIN->DONE->IDLE. CHECK->DONE if the line is not covered.
//  - IDLE: on start, latch line/sprite_x/sprite_y/sprite_en/mirror; go to CHECK.
//    start while busy is ignored (no queueing).
//  - CHECK: row = line - sprite_y as an 11-bit signed value. Covered iff sprite_en and
//    0 <= row <= 15. Covered -> FETCH with col=0, else DONE.
//  - FETCH: 16 cycles, col 0..15. Each cycle rom_chipselect=1, rom_address={row[3:0],col}.
//    Pipeline register carries col one cycle to match ROM latency.
//  - Write (cycle after each address): x = sprite_x + col_d as an 11-bit sum.
//    lb_we=1 iff rom_readdata != TRANSPARENT and x < H_ACTIVE; lb_addr=x[9:0];
//    lb_wdata=rom_readdata. No wrap-around: x >= H_ACTIVE (incl. 11-bit carry) is dropped.
//  - DRAIN: 1 cycle; completes the write for col 15; rom_chipselect=0.
//  - DONE: done=1 for exactly one cycle; then IDLE.
//  - Latency with start at cycle 0:
//    covered line: CHECK c1, FETCH c2..c17, lb_we possible c3..c18, done at c19.
//    uncovered line: CHECK c1, done at c2. busy is high from c1 until done, inclusive.
//  - Exactly 16 ROM reads per covered line, none per uncovered line.
//  - lb_we is 0 outside FETCH+1 .. DRAIN.
//  - Reset mid-FETCH: aborts immediately; no done pulse; no further writes.
// CONFIGURATION
//  SPRITE_MIRROR_EN defined: when latched mirror=1, rom_address col field = 15-col;
//  write x still uses col_d, so the sprite is flipped horizontally.
//  SPRITE_MIRROR_EN undefined: mirror port present but ignored; col field = col.
// STRUCTURE
//  Shared package sprite_pkg: SPR_DIM, H_ACTIVE, TRANSPARENT constants; state enum
//  fetch_state_t {IDLE,CHECK,FETCH,DRAIN,DONE}; sprite_pos_t struct {x[9:0], y[9:0], en}.
//  Single module; no sub-module (the pipeline is one register stage).
// TESTING
//  T1 line=100, sprite_y=95, sprite_x=200, ROM word n=n -> addrs 0x50..0x5F on c2..c17;
//     lb_addr 200..215 with data 0x50..0x5F on c3..c18; done at c19.
//  T2 line=94, sprite_y=95 (row -1) -> no rom_chipselect, no lb_we; done at c2.
//  T3 sprite_x=630, line=sprite_y -> writes lb_addr 630..639 only; cols 10..15 clipped.
//  T4 ROM row with cols 3,7 = 16'hF81F -> 14 writes; lb_addr sprite_x+3 and sprite_x+7 skipped.
//  T5 start re-pulsed at c5 -> ignored; exactly 16 reads, one done; sprite_en=0 -> done at c2.
//  T6 reset_n low at c8 -> all outputs 0 next edge-free; no done. With SPRITE_MIRROR_EN and
//     mirror=1: rom col field 15..0 while lb_addr ascends sprite_x..sprite_x+15.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite line fetcher: sprite geometry,
// visible line width, colour key, FSM state encoding and latched sprite position.
package sprite_pkg;

  localparam int          SPR_DIM     = 16;
  localparam int          H_ACTIVE    = 640;
  localparam logic [15:0] TRANSPARENT = 16'hF81F;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } sprite_pos_t;

endpackage

// File: rtl/sprite_line_fetcher_if.sv
// Sprite ROM read port plus VGA line-buffer write port, as seen by the fetcher
// (master) and by the memories it talks to (slave).
interface sprite_line_fetcher_if;

  logic [7:0]  rom_address;
  logic        rom_chipselect;
  logic        rom_clken;
  logic [15:0] rom_readdata;
  logic        lb_we;
  logic [9:0]  lb_addr;
  logic [15:0] lb_wdata;

  modport master (
    output rom_address, rom_chipselect, rom_clken,
    output lb_we, lb_addr, lb_wdata,
    input  rom_readdata
  );

  modport slave (
    input  rom_address, rom_chipselect, rom_clken,
    input  lb_we, lb_addr, lb_wdata,
    output rom_readdata
  );

endinterface

// File: rtl/sprite_line_fetcher.sv
// Copies one 16-pixel sprite row from the sprite ROM into the line buffer per hblank,
// skipping colour-keyed pixels and clipping at the right edge. Define SPRITE_MIRROR_EN
// to honour the mirror input (horizontal flip).
module sprite_line_fetcher
  import sprite_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [9:0]                    line,
  input  logic [9:0]                    sprite_x,
  input  logic [9:0]                    sprite_y,
  input  logic                          sprite_en,
  input  logic                          mirror,
  sprite_line_fetcher_if.master         bus,
  output logic                          busy,
  output logic                          done
);

  localparam logic [3:0]  COL_LAST = 4'(SPR_DIM - 1);
  localparam logic [10:0] X_LIMIT  = 11'(H_ACTIVE);

  fetch_state_t state, state_next;
  sprite_pos_t  pos_q;
  logic [9:0]   line_q;
  logic         mirror_q;
  logic [3:0]   col;
  logic [3:0]   col_d;
  logic         valid_d;
  logic         clken_q;

  logic [10:0]  row;
  logic         covered;
  logic [3:0]   rom_col;
  logic [10:0]  x_sum;

  // Signed distance of the requested line below the sprite top; fits in 11 bits.
  assign row     = {1'b0, line_q} - {1'b0, pos_q.y};
  assign covered = pos_q.en && (row[10:4] == 7'd0);

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what makes col_d trail col by exactly one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pos_q    <= '0;
      line_q   <= '0;
      mirror_q <= 1'b0;
      col      <= '0;
      col_d    <= '0;
      valid_d  <= 1'b0;
      clken_q  <= 1'b0;
    end else begin
      state   <= state_next;
      clken_q <= 1'b1;
      if (state == IDLE && start) begin
        pos_q    <= '{x: sprite_x, y: sprite_y, en: sprite_en};
        line_q   <= line;
        mirror_q <= mirror;
      end
      if (state == CHECK)      col <= '0;
      else if (state == FETCH) col <= col + 4'd1;
      // Address issued this cycle returns data next cycle; tag it with its column.
      col_d   <= col;
      valid_d <= (state == FETCH);
    end
  end

  // NOTE: next state defaults to the current state first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = CHECK;
      CHECK:   state_next = covered ? FETCH : DONE;
      FETCH:   if (col == COL_LAST) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef SPRITE_MIRROR_EN
  assign rom_col = mirror_q ? (COL_LAST - col) : col;
`else
  logic unused_mirror;
  assign unused_mirror = mirror_q;
  assign rom_col       = col;
`endif

  // Write position follows col_d regardless of mirroring; only the ROM read order flips.
  assign x_sum = {1'b0, pos_q.x} + {7'd0, col_d};

  always_comb begin
    bus.rom_chipselect = (state == FETCH);
    bus.rom_address    = (state == FETCH) ? {row[3:0], rom_col} : 8'd0;
    bus.rom_clken      = clken_q;
    bus.lb_we          = valid_d && (bus.rom_readdata != TRANSPARENT) && (x_sum < X_LIMIT);
    bus.lb_addr        = valid_d ? x_sum[9:0] : 10'd0;
    bus.lb_wdata       = valid_d ? bus.rom_readdata : 16'd0;
    busy               = (state != IDLE);
    done               = (state == DONE);
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Randomised bench for sprite_line_fetcher: a behavioural ROM plus a per-request
// reference model of every cycle's ROM reads, line-buffer writes, busy and done.
module tb_sprite_line_fetcher;
  import sprite_pkg::*;

`ifdef SPRITE_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif
  localparam int NCYC = 24;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] line = '0, sprite_x = '0, sprite_y = '0;
  logic       sprite_en = 1'b0, mirror = 1'b0;
  logic       busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom_mem [256];

  sprite_line_fetcher_if bus ();

  sprite_line_fetcher dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .line      (line),
    .sprite_x  (sprite_x),
    .sprite_y  (sprite_y),
    .sprite_en (sprite_en),
    .mirror    (mirror),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears the cycle after it is presented.
  always @(posedge clk) if (bus.rom_clken) bus.rom_readdata <= rom_mem[bus.rom_address];

  task automatic fill_rom_random();
    for (int i = 0; i < 256; i++)
      rom_mem[i] = ($urandom_range(0, 7) == 0) ? TRANSPARENT : 16'($urandom);
  endtask

  // Drive one request with start in cycle 0 and compare cycles 1..NCYC against the model.
  task automatic run_request(input string name, input logic [9:0] ln, input logic [9:0] sx,
                             input logic [9:0] sy, input bit en, input bit mir,
                             input int repulse_at);
    bit          exp_cs [NCYC+1];
    logic [7:0]  exp_ra [NCYC+1];
    bit          exp_we [NCYC+1];
    logic [9:0]  exp_la [NCYC+1];
    logic [15:0] exp_wd [NCYC+1];
    logic [38:0] obs, expv;
    int  row, done_c, x, exp_reads, exp_writes, reads, writes, dones;
    bit  cov;
    logic [7:0] a;
    for (int k = 0; k <= NCYC; k++) begin
      exp_cs[k] = 0; exp_ra[k] = '0; exp_we[k] = 0; exp_la[k] = '0; exp_wd[k] = '0;
    end
    row        = int'(ln) - int'(sy);
    cov        = en && row >= 0 && row < SPR_DIM;
    done_c     = cov ? 19 : 2;
    exp_reads  = cov ? SPR_DIM : 0;
    exp_writes = 0;
    if (cov) begin
      for (int c = 0; c < SPR_DIM; c++) begin
        a = 8'(row * 16 + ((mir && MIRROR_EN) ? 15 - c : c));
        exp_cs[c+2] = 1; exp_ra[c+2] = a;
        x = int'(sx) + c;
        if (rom_mem[a] != TRANSPARENT && x < H_ACTIVE) begin
          exp_we[c+3] = 1; exp_la[c+3] = 10'(x); exp_wd[c+3] = rom_mem[a];
          exp_writes++;
        end
      end
    end
    reads = 0; writes = 0; dones = 0;
    @(negedge clk);
    line = ln; sprite_x = sx; sprite_y = sy; sprite_en = en; mirror = mir; start = 1'b1;
    for (int k = 1; k <= NCYC; k++) begin
      @(negedge clk);
      start = (repulse_at > 0 && k == repulse_at - 1);
      // Scramble inputs while busy: the DUT must work from its latched copy.
      line = 10'($urandom); sprite_x = 10'($urandom); sprite_y = 10'($urandom);
      sprite_en = 1'($urandom); mirror = 1'($urandom);
      reads  += int'(bus.rom_chipselect);
      writes += int'(bus.lb_we);
      dones  += int'(done);
      obs  = {busy, done, bus.rom_chipselect, exp_cs[k] ? bus.rom_address : 8'd0, bus.lb_we,
              exp_we[k] ? bus.lb_addr : 10'd0, exp_we[k] ? bus.lb_wdata : 16'd0, bus.rom_clken};
      expv = {(k <= done_c), (k == done_c), exp_cs[k], exp_ra[k], exp_we[k],
              exp_la[k], exp_wd[k], 1'b1};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h (busy,done,cs,raddr,we,laddr,wdata,clken)",
                 name, k, obs, expv);
      end
    end
    start = 1'b0;
    n_checks++;
    if (reads !== exp_reads || writes !== exp_writes || dones !== 1) begin
      n_fail++;
      $display("FAIL %s counts: got reads=%0d writes=%0d dones=%0d expected %0d %0d 1",
               name, reads, writes, dones, exp_reads, exp_writes);
    end
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {busy, done, bus.rom_chipselect, bus.rom_address, bus.lb_we, bus.lb_addr,
           bus.lb_wdata, bus.rom_clken};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.rom_clken, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release: got clken,busy,done=%b expected 100",
                         {bus.rom_clken, busy, done});
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'(i);
    run_request("t1_basic", 10'd100, 10'd200, 10'd95, 1'b1, 1'b0, 0);
    fill_rom_random();
    run_request("row0", 10'd300, 10'd17, 10'd300, 1'b1, 1'b0, 0);
    run_request("row15", 10'd315, 10'd400, 10'd300, 1'b1, 1'b0, 0);
  endtask

  task automatic test_uncovered();
    run_request("t2_row_minus1", 10'd94, 10'd200, 10'd95, 1'b1, 1'b0, 0);
    run_request("row16", 10'd316, 10'd50, 10'd300, 1'b1, 1'b0, 0);
    run_request("wrap_neg", 10'd3, 10'd50, 10'd1000, 1'b1, 1'b0, 0);
  endtask

  task automatic test_clip();
    fill_rom_random();
    for (int c = 0; c < 16; c++) if (rom_mem[80 + c] == TRANSPARENT) rom_mem[80 + c] = 16'h1234;
    run_request("t3_clip630", 10'd205, 10'd630, 10'd200, 1'b1, 1'b0, 0);
    run_request("clip1020", 10'd205, 10'd1020, 10'd200, 1'b1, 1'b0, 0);
    run_request("edge624", 10'd205, 10'd624, 10'd200, 1'b1, 1'b0, 0);
  endtask

  task automatic test_transparent();
    for (int c = 0; c < 16; c++) rom_mem[32 + c] = 16'hA000 + 16'(c);
    rom_mem[32 + 3] = TRANSPARENT;
    rom_mem[32 + 7] = TRANSPARENT;
    run_request("t4_colour_key", 10'd52, 10'd100, 10'd50, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    fill_rom_random();
    run_request("t5_repulse", 10'd120, 10'd10, 10'd110, 1'b1, 1'b0, 5);
    run_request("t5_disabled", 10'd120, 10'd10, 10'd110, 1'b0, 1'b0, 0);
    run_request("b2b_next", 10'd121, 10'd11, 10'd110, 1'b1, 1'b0, 0);
  endtask

  task automatic test_mirror();
    fill_rom_random();
    run_request("t6_mirror", 10'd64, 10'd300, 10'd60, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [9:0] sy;
    for (int n = 0; n < 24; n++) begin
      fill_rom_random();
      sy = 10'($urandom_range(0, 1000));
      run_request("random", 10'(int'(sy) + $urandom_range(0, 20) - 2), 10'($urandom),
                  sy, ($urandom_range(0, 5) != 0), 1'($urandom), 0);
    end
  endtask

  task automatic test_reset_abort();
    logic [38:0] obs;
    int bad;
    fill_rom_random();
    for (int c = 0; c < 16; c++) rom_mem[16 + c] = 16'h0F0F;
    @(negedge clk);
    line = 10'd41; sprite_x = 10'd5; sprite_y = 10'd40; sprite_en = 1'b1; mirror = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    obs = {busy, done, bus.rom_chipselect, bus.rom_address, bus.lb_we, bus.lb_addr,
           bus.lb_wdata, bus.rom_clken};
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got %h expected 0", obs);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      bad += int'(bus.lb_we || done || busy || bus.rom_chipselect);
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_uncovered();
    test_clip();
    test_transparent();
    test_back_to_back();
    test_mirror();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
